// File: rtl/pfd_freq_lock_ctrl.sv
// Phase/frequency detector with windowed frequency comparison and lock FSM.
// All logic runs on samp_clk; ref_in and fb_in are asynchronous and are
// oversampled through synchroniser chains before edge detection.
//
// Output pulse semantics: phase_valid and freq_check_done are single-cycle
// strobes with no back-pressure; a consumer must sample them every cycle.
// phase_err is valid in the phase_valid cycle and holds until the next one.
// ref_clk_is_faster/slower hold the result of the most recent window.
module pfd_freq_lock_ctrl #(
    parameter int SYNC_STAGES  = 2,
    parameter int CNT_W        = 16,
    parameter int WIN_EDGES    = 64,
    parameter int FREQ_TOL     = 1,
    parameter int LOCK_WINDOWS = 4,
    parameter int PHASE_W      = 8
) (
    input  logic                      samp_clk,
    input  logic                      rst_n,
    input  logic                      en,
    input  logic                      ref_in,
    input  logic                      fb_in,
    output logic                      up,
    output logic                      down,
    output logic signed [PHASE_W-1:0] phase_err,
    output logic                      phase_valid,
    output logic                      ref_clk_is_faster,
    output logic                      ref_clk_is_slower,
    output logic                      freq_check_done,
    output logic                      calibration_done,
    output logic [1:0]                state
);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        FREQ_CHECK = 2'd1,
        LOCKED     = 2'd2
    } state_t;

    localparam int GOOD_W = (LOCK_WINDOWS < 2) ? 1 : $clog2(LOCK_WINDOWS + 1);
    localparam logic [CNT_W-1:0]        WIN_LAST = CNT_W'(WIN_EDGES - 1);
    localparam logic signed [CNT_W:0]   TOL_S    = (CNT_W+1)'(FREQ_TOL);
    localparam logic [PHASE_W-1:0]      PH_MAX   = {1'b0, {(PHASE_W-1){1'b1}}};

    state_t                  state_q, state_d;
    logic [GOOD_W-1:0]       good_q, good_d;

    logic [SYNC_STAGES-1:0]  ref_sync, fb_sync;
    logic                    ref_prev, fb_prev;
    logic                    run, ref_rise, fb_rise;

    logic [PHASE_W-1:0]      ph_cnt, ph_inc;
    logic                    up_nx, down_nx;

    logic [CNT_W-1:0]        ref_cnt, fb_cnt, fb_cnt_inc;
    logic [CNT_W:0]          ref_fin;
    logic signed [CNT_W:0]   diff;
    logic                    win_close, too_fast, too_slow, matched;

    // Synchronisers and edge-history flops; only reset clears them, en does not.
    always_ff @(posedge samp_clk) begin
        if (rst_n) begin
            ref_sync <= '0;
            fb_sync  <= '0;
            ref_prev <= 1'b0;
            fb_prev  <= 1'b0;
        end else begin
            ref_sync <= {ref_sync[SYNC_STAGES-2:0], ref_in};
            fb_sync  <= {fb_sync[SYNC_STAGES-2:0], fb_in};
            ref_prev <= ref_sync[SYNC_STAGES-1];
            fb_prev  <= fb_sync[SYNC_STAGES-1];
        end
    end

    // Edge pulses, window arithmetic and PFD next values.
    always_comb begin
        run        = en && (state_q != IDLE);
        ref_rise   = run && ref_sync[SYNC_STAGES-1] && !ref_prev;
        fb_rise    = run && fb_sync[SYNC_STAGES-1] && !fb_prev;

        up_nx      = up | ref_rise;
        down_nx    = down | fb_rise;
        ph_inc     = (ph_cnt == PH_MAX) ? ph_cnt : ph_cnt + PHASE_W'(1);

        // An fb edge coinciding with the closing ref edge belongs to this window.
        fb_cnt_inc = (fb_rise && (fb_cnt != '1)) ? fb_cnt + CNT_W'(1) : fb_cnt;
        win_close  = ref_rise && (ref_cnt == WIN_LAST);
        ref_fin    = {1'b0, ref_cnt} + (CNT_W+1)'(1);
        diff       = $signed(ref_fin) - $signed({1'b0, fb_cnt_inc});
        too_fast   = diff > TOL_S;
        too_slow   = diff < -TOL_S;
        matched    = !too_fast && !too_slow;
    end

    // Lock FSM next-state; good_q counts consecutive matched windows.
    always_comb begin
        state_d = state_q;
        good_d  = good_q;
        case (state_q)
            IDLE: begin
                good_d = '0;
                if (en) state_d = FREQ_CHECK;
            end
            FREQ_CHECK: begin
                if (win_close) begin
                    if (!matched) begin
                        good_d = '0;
                    end else if (good_q == GOOD_W'(LOCK_WINDOWS - 1)) begin
                        good_d  = '0;
                        state_d = LOCKED;
                    end else begin
                        good_d = good_q + GOOD_W'(1);
                    end
                end
            end
            LOCKED: begin
                good_d = '0;
                if (win_close && !matched) state_d = FREQ_CHECK;
            end
            default: begin
                good_d  = '0;
                state_d = IDLE;
            end
        endcase
        if (!en) begin
            state_d = IDLE;
            good_d  = '0;
        end
    end

    // Lock FSM state register.
    always_ff @(posedge samp_clk) begin
        if (rst_n) begin
            state_q <= IDLE;
            good_q  <= '0;
        end else begin
            state_q <= state_d;
            good_q  <= good_d;
        end
    end

    // PFD pulses, phase measurement and window counters; cleared when not running.
    always_ff @(posedge samp_clk) begin
        if (rst_n || !run) begin
            up                <= 1'b0;
            down              <= 1'b0;
            ph_cnt            <= '0;
            phase_err         <= '0;
            phase_valid       <= 1'b0;
            ref_cnt           <= '0;
            fb_cnt            <= '0;
            ref_clk_is_faster <= 1'b0;
            ref_clk_is_slower <= 1'b0;
            freq_check_done   <= 1'b0;
        end else begin
            phase_valid     <= 1'b0;
            freq_check_done <= win_close;
            if (up_nx && down_nx) begin
                // Second edge of a pair: close the pulse and report the lead.
                up          <= 1'b0;
                down        <= 1'b0;
                ph_cnt      <= '0;
                phase_valid <= 1'b1;
                if (up)
                    phase_err <= $signed(ph_cnt);
                else if (down)
                    phase_err <= -$signed(ph_cnt);
                else
                    phase_err <= '0;
            end else begin
                up     <= up_nx;
                down   <= down_nx;
                ph_cnt <= (up_nx || down_nx) ? ph_inc : '0;
            end

            if (win_close) begin
                ref_cnt           <= '0;
                fb_cnt            <= '0;
                ref_clk_is_faster <= too_fast;
                ref_clk_is_slower <= too_slow;
            end else begin
                ref_cnt <= ref_cnt + {{(CNT_W-1){1'b0}}, ref_rise};
                fb_cnt  <= fb_cnt_inc;
            end
        end
    end

    assign state            = state_q;
    assign calibration_done = (state_q == LOCKED);

endmodule

// File: tb/tb_pfd_freq_lock_ctrl.sv
// Scoreboard bench for pfd_freq_lock_ctrl: edge lists are generated per
// scenario, an event-level model derives expected phase and window results,
// and a monitor compares them whenever the DUT strobes an output.
module tb_pfd_freq_lock_ctrl;

    localparam int SYNC_STAGES  = 2;
    localparam int CNT_W        = 16;
    localparam int WIN_EDGES    = 64;
    localparam int FREQ_TOL     = 1;
    localparam int LOCK_WINDOWS = 4;
    localparam int PHASE_W      = 8;
    localparam int PH_SAT       = (1 << (PHASE_W - 1)) - 1;

    // clock / reset
    logic samp_clk = 1'b0;
    always #5 samp_clk = ~samp_clk;

    logic                      rst_n = 1'b1;
    logic                      en = 1'b0;
    logic                      ref_in = 1'b0;
    logic                      fb_in = 1'b0;
    logic                      up, down, phase_valid;
    logic signed [PHASE_W-1:0] phase_err;
    logic                      ref_clk_is_faster, ref_clk_is_slower;
    logic                      freq_check_done, calibration_done;
    logic [1:0]                state;

    pfd_freq_lock_ctrl #(
        .SYNC_STAGES (SYNC_STAGES),
        .CNT_W       (CNT_W),
        .WIN_EDGES   (WIN_EDGES),
        .FREQ_TOL    (FREQ_TOL),
        .LOCK_WINDOWS(LOCK_WINDOWS),
        .PHASE_W     (PHASE_W)
    ) dut (
        .samp_clk         (samp_clk),
        .rst_n            (rst_n),
        .en               (en),
        .ref_in           (ref_in),
        .fb_in            (fb_in),
        .up               (up),
        .down             (down),
        .phase_err        (phase_err),
        .phase_valid      (phase_valid),
        .ref_clk_is_faster(ref_clk_is_faster),
        .ref_clk_is_slower(ref_clk_is_slower),
        .freq_check_done  (freq_check_done),
        .calibration_done (calibration_done),
        .state            (state)
    );

    // scoreboard state
    int n_pass  = 0;
    int n_total = 0;
    logic [PHASE_W-1:0] ph_exp_q[$];
    logic [4:0]         fr_exp_q[$];   // {faster, slower, cal_done, state}
    int ref_t[$];
    int fb_t[$];
    bit ref_w[];
    bit fb_w[];
    bit saw_down;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    function automatic logic [31:0] all_outputs();
        return {15'd0, up, down, phase_err, phase_valid, ref_clk_is_faster,
                ref_clk_is_slower, freq_check_done, calibration_done, state};
    endfunction

    // monitor: pop and compare whenever the DUT strobes a result
    logic [PHASE_W-1:0] mon_pe;
    logic [4:0]         mon_fe;
    always @(negedge samp_clk) begin
        if (down) saw_down = 1'b1;
        if (!rst_n && phase_valid) begin
            check("up_down_exclusive", {31'd0, up & down}, 32'd0);
            if (ph_exp_q.size() == 0) begin
                check("phase_valid_unexpected", 32'd1, 32'd0);
            end else begin
                mon_pe = ph_exp_q.pop_front();
                check("phase_err", {24'd0, phase_err}, {24'd0, mon_pe});
            end
        end
        if (!rst_n && freq_check_done) begin
            if (fr_exp_q.size() == 0) begin
                check("freq_check_done_unexpected", 32'd1, 32'd0);
            end else begin
                mon_fe = fr_exp_q.pop_front();
                check("window_result", {27'd0, ref_clk_is_faster, ref_clk_is_slower,
                                        calibration_done, state}, {27'd0, mon_fe});
            end
        end
    end

    // Build edge lists: ref periodic; fb periodic with optional period switch and drops.
    task automatic gen(input int pr, input int nref, input int pf, input int off,
                       input int sw, input int pf2, input int da, input int db);
        int t;
        int i;
        ref_t.delete();
        fb_t.delete();
        for (int k = 0; k < nref; k++) ref_t.push_back(2 + k * pr);
        t = 2 + off;
        i = 0;
        while (t <= ref_t[nref-1] + pr) begin
            if (i != da && i != db) fb_t.push_back(t);
            t += (sw >= 0 && i >= sw) ? pf2 : pf;
            i++;
        end
    endtask

    // Reference model: pair edges into phase measurements, group ref edges into windows.
    task automatic build_expect();
        int i, j, pend, t0, t, v, prev, close_t, cnt, d, good, st;
        bit r, f, fast, slow;
        i = 0; j = 0; pend = 0; t0 = 0;
        while (i < ref_t.size() || j < fb_t.size()) begin
            if (i >= ref_t.size()) t = fb_t[j];
            else if (j >= fb_t.size()) t = ref_t[i];
            else t = (ref_t[i] < fb_t[j]) ? ref_t[i] : fb_t[j];
            r = (i < ref_t.size()) && (ref_t[i] == t);
            f = (j < fb_t.size()) && (fb_t[j] == t);
            if (r) i++;
            if (f) j++;
            v = (t - t0 > PH_SAT) ? PH_SAT : t - t0;
            if (r && f) begin
                if (pend == 0) ph_exp_q.push_back('0);
                else if (pend == 1) ph_exp_q.push_back(PHASE_W'(v));
                else ph_exp_q.push_back(PHASE_W'(-v));
                pend = 0;
            end else if (r) begin
                if (pend == 2) begin ph_exp_q.push_back(PHASE_W'(-v)); pend = 0; end
                else if (pend == 0) begin pend = 1; t0 = t; end
            end else begin
                if (pend == 1) begin ph_exp_q.push_back(PHASE_W'(v)); pend = 0; end
                else if (pend == 0) begin pend = 2; t0 = t; end
            end
        end
        prev = -1; good = 0; st = 1;
        for (int k = 0; k < ref_t.size() / WIN_EDGES; k++) begin
            close_t = ref_t[(k + 1) * WIN_EDGES - 1];
            cnt = 0;
            foreach (fb_t[n]) if (fb_t[n] > prev && fb_t[n] <= close_t) cnt++;
            d = WIN_EDGES - cnt;
            fast = d > FREQ_TOL;
            slow = d < -FREQ_TOL;
            if (st == 1) begin
                if (fast || slow) good = 0;
                else begin
                    good++;
                    if (good == LOCK_WINDOWS) begin st = 2; good = 0; end
                end
            end else if (fast || slow) begin
                st = 1; good = 0;
            end
            fr_exp_q.push_back({fast, slow, st == 2, 2'(st)});
            prev = close_t;
        end
    endtask

    task automatic wait_freq_check();
        for (int k = 0; k < 20; k++) begin
            @(negedge samp_clk);
            if (state == 2'd1) break;
        end
        check("enter_freq_check", {30'd0, state}, 32'd1);
    endtask

    task automatic start_enabled();
        en = 1'b0; ref_in = 1'b0; fb_in = 1'b0;
        repeat (SYNC_STAGES + 4) @(negedge samp_clk);
        en = 1'b1;
        wait_freq_check();
        repeat (3) @(negedge samp_clk);
    endtask

    // driver: run one scenario from the current edge lists
    task automatic run_scenario(input string name);
        int len;
        start_enabled();
        build_expect();
        len = ((ref_t[$] > fb_t[$]) ? ref_t[$] : fb_t[$]) + 4;
        ref_w = new[len];
        fb_w  = new[len];
        foreach (ref_t[n]) begin ref_w[ref_t[n]] = 1'b1; ref_w[ref_t[n]+1] = 1'b1; end
        foreach (fb_t[n])  begin fb_w[fb_t[n]]   = 1'b1; fb_w[fb_t[n]+1]   = 1'b1; end
        for (int c = 0; c < len; c++) begin
            @(negedge samp_clk);
            ref_in = ref_w[c];
            fb_in  = fb_w[c];
        end
        ref_in = 1'b0; fb_in = 1'b0;
        repeat (30) @(negedge samp_clk);
        check({name, "_phase_left"}, ph_exp_q.size(), 32'd0);
        check({name, "_window_left"}, fr_exp_q.size(), 32'd0);
        ph_exp_q.delete();
        fr_exp_q.delete();
        en = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        int pr, pf;
        // reset state
        rst_n = 1'b1;
        repeat (3) @(negedge samp_clk);
        check("reset_outputs", all_outputs(), 32'd0);
        rst_n = 1'b0;

        // phase lead: fb 3 cycles late, locks after 4 windows
        gen(10, 4 * WIN_EDGES + 5, 10, 3, -1, 0, -1, -1);
        saw_down = 1'b0;
        run_scenario("lead");
        check("lead_no_down", {31'd0, saw_down}, 32'd0);

        // identical waveforms
        gen(10, 4 * WIN_EDGES + 5, 10, 0, -1, 0, -1, -1);
        run_scenario("simultaneous");

        // fb slower: ref faster every window
        gen(10, 3 * WIN_EDGES + 5, 12, 0, -1, 0, -1, -1);
        run_scenario("freq_offset");

        // lock, then fb speeds up -> loss of lock
        gen(10, 5 * WIN_EDGES + 5, 10, 2, 4 * WIN_EDGES, 8, -1, -1);
        run_scenario("loss_of_lock");

        // tolerance edge: 63 then 62 fb edges
        gen(10, 7 * WIN_EDGES + 5, 10, 1, -1, 0, 70, 80);
        run_scenario("tolerance");

        // randomized periods and offsets
        for (int s = 0; s < 3; s++) begin
            pr = $urandom_range(6, 12);
            pf = pr + $urandom_range(0, 2) - 1;
            gen(pr, 3 * WIN_EDGES + 5, pf, $urandom_range(0, pr - 1), -1, 0, -1, -1);
            run_scenario("random");
        end

        // reset mid-pulse and mid-window
        start_enabled();
        @(negedge samp_clk) ref_in = 1'b1;
        @(negedge samp_clk);
        @(negedge samp_clk) ref_in = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (up) break;
            @(negedge samp_clk);
        end
        check("up_before_reset", {31'd0, up}, 32'd1);
        rst_n = 1'b1;
        @(negedge samp_clk);
        check("mid_pulse_reset_outputs", all_outputs(), 32'd0);
        rst_n = 1'b0;
        repeat (30) @(negedge samp_clk);
        check("state_after_reset", {30'd0, state}, 32'd1);
        check("up_after_reset", {31'd0, up}, 32'd0);

        // en=0 holds everything at zero regardless of inputs
        en = 1'b0;
        repeat (2) @(negedge samp_clk);
        for (int k = 0; k < 60; k++) begin
            @(negedge samp_clk);
            ref_in = 1'($urandom_range(0, 1));
            fb_in  = 1'($urandom_range(0, 1));
            if (k % 6 == 5) check("disabled_outputs", all_outputs(), 32'd0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
